// File: rtl/battle_pkg.sv
// Shared types and helpers for the turn-based battle core: FSM encoding,
// PS/2 set-2 key codes and saturating HP arithmetic.
package battle_pkg;

    localparam int HP_W = 8;

    typedef logic [HP_W-1:0] hp_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_P_TURN    = 3'd1,
        S_P_RESOLVE = 3'd2,
        S_E_WAIT    = 3'd3,
        S_E_RESOLVE = 3'd4,
        S_WIN       = 3'd5,
        S_DEAD      = 3'd6
    } battle_state_e;

    localparam logic [7:0] KEY_J = 8'h3B;
    localparam logic [7:0] KEY_K = 8'h42;
    localparam logic [7:0] KEY_L = 8'h4B;
    localparam logic [7:0] KEY_I = 8'h43;

    function automatic hp_t sat_sub(input hp_t a, input hp_t b);
        return (a <= b) ? '0 : hp_t'(a - b);
    endfunction

    // Sum is formed one bit wider so the clamp sees the true total.
    function automatic hp_t sat_add(input hp_t a, input hp_t b, input hp_t lim);
        logic [HP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[HP_W-1:0];
    endfunction

endpackage

// File: rtl/battle_if.sv
// Signal bundle between the battle engine and its producers/consumers.
// key_valid/start/clear_game are single-cycle strobes with no ready: the
// engine either acts on them in the cycle they are high or drops them.
interface battle_if;
    import battle_pkg::*;

    logic          start;
    logic          clear_game;
    logic          clk_1s;
    logic          key_valid;
    logic [7:0]    key_code;
    hp_t           php;
    hp_t           ehp;
    logic          busy;
    logic          player_turn;
    logic          win_pulse;
    logic          dead_pulse;
    logic [2:0]    wins;
    logic          game_won;
    battle_state_e dbg_state;

    modport master (
        output start, clear_game, clk_1s, key_valid, key_code,
        input  php, ehp, busy, player_turn, win_pulse, dead_pulse, wins, game_won, dbg_state
    );

    modport slave (
        input  start, clear_game, clk_1s, key_valid, key_code,
        output php, ehp, busy, player_turn, win_pulse, dead_pulse, wins, game_won, dbg_state
    );

endinterface

// File: rtl/tick_edge.sv
// Synchronises a slow level (e.g. the 1 Hz divider output) and emits a
// registered one-cycle strobe on each rising edge.
module tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic tick_o
);

    logic sync_q;
    logic prev_q;
    logic tick_q;

    // Both history registers load the live level in reset so a level that is
    // already high does not look like a fresh edge afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= lvl_i;
            prev_q <= lvl_i;
            tick_q <= 1'b0;
        end else begin
            sync_q <= lvl_i;
            prev_q <= sync_q;
            tick_q <= sync_q & ~prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/battle_engine.sv
// Turn-based combat core: player action, delayed enemy hit, win/death
// bookkeeping and the battle-win counter for the game FSM.
module battle_engine
    import battle_pkg::*;
#(
    parameter hp_t        PLAYER_HP_MAX  = 8'd100,
    parameter hp_t        ENEMY_HP_MAX   = 8'd80,
    parameter hp_t        LIGHT_DMG      = 8'd10,
    parameter hp_t        HEAVY_DMG      = 8'd25,
    parameter hp_t        HEAL_AMT       = 8'd15,
    parameter hp_t        ENEMY_DMG      = 8'd12,
    parameter logic [1:0] HEAVY_COOLDOWN = 2'd2,
    parameter logic [1:0] ENEMY_DELAY    = 2'd2,
    parameter logic [2:0] WINS_TO_FINISH = 3'd5
) (
    input logic     clk,
    input logic     rst,
    battle_if.slave bus
);

    localparam logic [1:0] TCNT_LAST = ENEMY_DELAY - 2'd1;

    battle_state_e state_q;
    hp_t           php_q, ehp_q, dmg_q;
    logic [2:0]    wins_q;
    logic [1:0]    cooldown_q, tcnt_q;
    logic          game_won_q, win_pulse_q, dead_pulse_q;
    logic          busy_q, pturn_q, defend_q;
    logic          tick;
    logic          is_j, is_k, is_l, is_i, key_ok;
    hp_t           hit;

    tick_edge u_tick (
        .clk    (clk),
        .rst    (rst),
        .lvl_i  (bus.clk_1s),
        .tick_o (tick)
    );

    assign is_j   = (bus.key_code == KEY_J);
    assign is_k   = (bus.key_code == KEY_K);
    assign is_l   = (bus.key_code == KEY_L);
    assign is_i   = (bus.key_code == KEY_I);
    // K while cooling down is treated exactly like an unknown key.
    assign key_ok = bus.key_valid && (is_j || (is_k && cooldown_q == 2'd0) || is_l || is_i);
    assign hit    = defend_q ? (ENEMY_DMG >> 1) : ENEMY_DMG;

    always_ff @(posedge clk) begin
        if (!rst || bus.clear_game) begin
            state_q      <= S_IDLE;
            php_q        <= PLAYER_HP_MAX;
            ehp_q        <= ENEMY_HP_MAX;
            dmg_q        <= '0;
            wins_q       <= '0;
            cooldown_q   <= '0;
            tcnt_q       <= '0;
            game_won_q   <= 1'b0;
            win_pulse_q  <= 1'b0;
            dead_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            pturn_q      <= 1'b0;
            defend_q     <= 1'b0;
        end else begin
            win_pulse_q  <= 1'b0;
            dead_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        ehp_q      <= ENEMY_HP_MAX;
                        defend_q   <= 1'b0;
                        cooldown_q <= '0;
                        state_q    <= S_P_TURN;
                        busy_q     <= 1'b1;
                        pturn_q    <= 1'b1;
                    end
                end
                S_P_TURN: begin
                    if (key_ok) begin
                        state_q <= S_P_RESOLVE;
                        pturn_q <= 1'b0;
                        dmg_q   <= is_j ? LIGHT_DMG : (is_k ? HEAVY_DMG : '0);
                        if (is_k) cooldown_q <= HEAVY_COOLDOWN;
                        if (is_l) php_q <= sat_add(php_q, HEAL_AMT, PLAYER_HP_MAX);
                        if (is_i) defend_q <= 1'b1;
                    end
                end
                S_P_RESOLVE: begin
                    ehp_q <= sat_sub(ehp_q, dmg_q);
                    if (ehp_q <= dmg_q) begin
                        state_q <= S_WIN;
                    end else begin
                        state_q <= S_E_WAIT;
                        tcnt_q  <= '0;
                    end
                end
                S_E_WAIT: begin
                    if (tick) begin
                        if (tcnt_q == TCNT_LAST) state_q <= S_E_RESOLVE;
                        else                     tcnt_q  <= tcnt_q + 2'd1;
                    end
                end
                S_E_RESOLVE: begin
                    php_q    <= sat_sub(php_q, hit);
                    defend_q <= 1'b0;
                    if (cooldown_q != 2'd0) cooldown_q <= cooldown_q - 2'd1;
                    if (php_q <= hit) begin
                        state_q <= S_DEAD;
                    end else begin
                        state_q <= S_P_TURN;
                        pturn_q <= 1'b1;
                    end
                end
                S_WIN: begin
                    win_pulse_q <= 1'b1;
                    if (wins_q != WINS_TO_FINISH) wins_q <= wins_q + 3'd1;
                    if (wins_q >= WINS_TO_FINISH - 3'd1) game_won_q <= 1'b1;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_DEAD: begin
                    dead_pulse_q <= 1'b1;
                    php_q        <= PLAYER_HP_MAX;
                    wins_q       <= '0;
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    pturn_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.php         = php_q;
    assign bus.ehp         = ehp_q;
    assign bus.busy        = busy_q;
    assign bus.player_turn = pturn_q;
    assign bus.win_pulse   = win_pulse_q;
    assign bus.dead_pulse  = dead_pulse_q;
    assign bus.wins        = wins_q;
    assign bus.game_won    = game_won_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_battle_engine.sv
// Self-checking bench for battle_engine: directed sequences, a table-driven
// battle and model-driven battles feeding an expected-result queue.
module tb_battle_engine;
    import battle_pkg::*;

    localparam int SB_W = 20;

    typedef struct {
        logic [7:0] key;
        logic [7:0] ehp_a;
        logic [7:0] php_a;
        logic [7:0] php_b;
    } vec_t;

    logic clk;
    logic rst;
    battle_if bus ();

    battle_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [SB_W-1:0] exp_q[$];

    logic [7:0] m_php, m_ehp;
    logic [2:0] m_wins;
    logic       m_gw, m_def;
    int         m_cd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp();
        exp_q.push_back({m_php, m_ehp, m_wins, m_gw});
    endtask

    // Scoreboard: a turn or a battle ends when player_turn rises or busy falls.
    logic prev_pt, prev_busy;
    always @(negedge clk) begin
        logic [SB_W-1:0] e;
        if (rst === 1'b1) begin
            if ((bus.player_turn === 1'b1 && prev_pt === 1'b0) ||
                (bus.busy === 1'b0 && prev_busy === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got event with php=%0d ehp=%0d, required none", bus.php, bus.ehp);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_php_ehp_wins_gw", {bus.php, bus.ehp, bus.wins, bus.game_won}, 32'(e));
                end
            end
        end
        prev_pt   <= bus.player_turn;
        prev_busy <= bus.busy;
    end

    task automatic m_key(input logic [7:0] code, output int oc);
        logic [7:0] dmg, hit;
        logic rec;
        dmg = 8'd0;
        rec = 1'b1;
        case (code)
            KEY_J: dmg = 8'd10;
            KEY_K: if (m_cd == 0) begin dmg = 8'd25; m_cd = 2; end else rec = 1'b0;
            KEY_L: m_php = (m_php + 15 > 100) ? 8'd100 : m_php + 8'd15;
            KEY_I: m_def = 1'b1;
            default: rec = 1'b0;
        endcase
        if (!rec) begin
            oc = 0;
        end else begin
            m_ehp = (m_ehp <= dmg) ? 8'd0 : m_ehp - dmg;
            if (m_ehp == 0) begin
                if (m_wins < 5) m_wins = m_wins + 3'd1;
                if (m_wins == 5) m_gw = 1'b1;
                oc = 2;
            end else begin
                hit   = m_def ? 8'd6 : 8'd12;
                m_php = (m_php <= hit) ? 8'd0 : m_php - hit;
                m_def = 1'b0;
                if (m_cd > 0) m_cd--;
                if (m_php == 0) begin
                    m_php  = 8'd100;
                    m_wins = 3'd0;
                    oc = 3;
                end else begin
                    oc = 1;
                end
            end
        end
    endtask

    task automatic m_clear(input logic was_busy);
        m_php = 8'd100; m_ehp = 8'd80; m_wins = 3'd0; m_gw = 1'b0; m_cd = 0; m_def = 1'b0;
        if (was_busy) push_exp();
    endtask

    task automatic start_battle();
        @(negedge clk);
        bus.start = 1'b1;
        m_ehp = 8'd80; m_def = 1'b0; m_cd = 0;
        push_exp();
        @(negedge clk);
        bus.start = 1'b0;
        check("start_pt", bus.player_turn, 1);
        check("start_busy", bus.busy, 1);
    endtask

    task automatic send_key(input logic [7:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    // which: 0 waits on player_turn, 1 on busy; an expired budget fails the check.
    task automatic wait_flag(input string name, input int which, input logic val);
        int n;
        n = 0;
        while (((which == 0) ? bus.player_turn : bus.busy) !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, (which == 0) ? bus.player_turn : bus.busy, 32'(val));
    endtask

    // One full 1 s period, then a second rising edge left high for the caller.
    task automatic enemy_ticks();
        bus.clk_1s = 1'b1;
        repeat (3) @(negedge clk);
        bus.clk_1s = 1'b0;
        repeat (3) @(negedge clk);
        bus.clk_1s = 1'b1;
    endtask

    task automatic play_key(input logic [7:0] code, output int oc,
                            output logic [7:0] php_a, output logic [7:0] ehp_a);
        m_key(code, oc);
        if (oc != 0) push_exp();
        send_key(code);
        @(negedge clk);
        php_a = bus.php;
        ehp_a = bus.ehp;
        check("ehp_n2", bus.ehp, m_ehp);
        case (oc)
            0: check("ignored_state", 32'(bus.dbg_state), 32'(S_P_TURN));
            1: begin
                check("ewait_state", 32'(bus.dbg_state), 32'(S_E_WAIT));
                enemy_ticks();
                wait_flag("pt_return", 0, 1'b1);
                bus.clk_1s = 1'b0;
            end
            2: begin
                check("win_state", 32'(bus.dbg_state), 32'(S_WIN));
                @(negedge clk);
                check("win_pulse_hi", bus.win_pulse, 1);
                check("win_busy_lo", bus.busy, 0);
                @(negedge clk);
                check("win_pulse_lo", bus.win_pulse, 0);
            end
            default: begin
                check("ewait_state", 32'(bus.dbg_state), 32'(S_E_WAIT));
                enemy_ticks();
                wait_flag("dead_idle", 1, 1'b0);
                check("dead_pulse_hi", bus.dead_pulse, 1);
                check("dead_state", 32'(bus.dbg_state), 32'(S_IDLE));
                @(negedge clk);
                check("dead_pulse_lo", bus.dead_pulse, 0);
                bus.clk_1s = 1'b0;
            end
        endcase
    endtask

    vec_t tbl[9];

    initial begin
        int oc;
        logic [7:0] pa, ea, k;
        logic over;

        tbl[0] = '{KEY_K, 8'd55, 8'd100, 8'd88};
        tbl[1] = '{KEY_K, 8'd55, 8'd88,  8'd88};
        tbl[2] = '{8'h1C, 8'd55, 8'd88,  8'd88};
        tbl[3] = '{KEY_L, 8'd55, 8'd100, 8'd88};
        tbl[4] = '{KEY_I, 8'd55, 8'd88,  8'd82};
        tbl[5] = '{KEY_K, 8'd30, 8'd82,  8'd70};
        tbl[6] = '{KEY_J, 8'd20, 8'd70,  8'd58};
        tbl[7] = '{KEY_J, 8'd10, 8'd58,  8'd46};
        tbl[8] = '{KEY_J, 8'd0,  8'd46,  8'd46};

        // Clock/reset
        rst = 1'b0;
        bus.start = 1'b0; bus.clear_game = 1'b0; bus.clk_1s = 1'b0;
        bus.key_valid = 1'b0; bus.key_code = 8'h00;
        m_clear(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_php", bus.php, 100);
        check("rst_ehp", bus.ehp, 80);
        check("rst_wins", bus.wins, 0);
        check("rst_game_won", bus.game_won, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pt", bus.player_turn, 0);
        check("rst_strobes", {bus.win_pulse, bus.dead_pulse}, 0);
        check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));

        // Keys in IDLE do nothing
        send_key(KEY_J);
        @(negedge clk);
        check("idle_key_state", 32'(bus.dbg_state), 32'(S_IDLE));
        check("idle_key_ehp", bus.ehp, 80);

        // First light attack and enemy reply
        start_battle();
        play_key(KEY_J, oc, pa, ea);
        check("j_ehp", ea, 70);
        check("j_php_after_hit", bus.php, 88);
        check("j_pt", bus.player_turn, 1);

        // start outside IDLE is ignored
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        check("start_in_pturn_state", 32'(bus.dbg_state), 32'(S_P_TURN));
        check("start_in_pturn_ehp", bus.ehp, 70);

        // clear_game in E_WAIT coinciding with a tick and a key
        m_key(KEY_J, oc);
        send_key(KEY_J);
        @(negedge clk);
        check("pre_clear_state", 32'(bus.dbg_state), 32'(S_E_WAIT));
        check("pre_clear_ehp", bus.ehp, 60);
        bus.clk_1s = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.clear_game = 1'b1; bus.key_valid = 1'b1; bus.key_code = KEY_K;
        m_clear(1'b1);
        @(negedge clk);
        bus.clear_game = 1'b0; bus.key_valid = 1'b0;
        check("clear_state", 32'(bus.dbg_state), 32'(S_IDLE));
        check("clear_php", bus.php, 100);
        check("clear_ehp", bus.ehp, 80);
        check("clear_wins", bus.wins, 0);
        check("clear_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            check("clear_no_strobe", {bus.win_pulse, bus.dead_pulse}, 0);
            @(negedge clk);
        end
        bus.clk_1s = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven battle: cooldown, ignored keys, heal clamp, defend
        start_battle();
        for (int i = 0; i < 9; i++) begin
            play_key(tbl[i].key, oc, pa, ea);
            check("tbl_ehp_a", ea, tbl[i].ehp_a);
            check("tbl_php_a", pa, tbl[i].php_a);
            check("tbl_php_b", bus.php, tbl[i].php_b);
        end
        check("tbl_wins", bus.wins, 1);
        check("tbl_game_won", bus.game_won, 0);

        // Battles 2..6 driven by a simple player policy
        for (int b = 2; b <= 6; b++) begin
            start_battle();
            over = 1'b0;
            for (int t = 0; t < 200 && !over; t++) begin
                k = (m_php < 40) ? KEY_L : ((m_cd == 0) ? KEY_K : KEY_J);
                play_key(k, oc, pa, ea);
                over = (oc >= 2);
            end
            check("battle_over", over, 1);
            check("battle_wins", bus.wins, (b > 5) ? 5 : b);
            check("battle_game_won", bus.game_won, (b >= 5) ? 1 : 0);
        end

        // Death: defend down to <=12, then take a full hit
        start_battle();
        over = 1'b0;
        for (int t = 0; t < 40 && !over; t++) begin
            k = (m_php <= 12) ? KEY_J : KEY_I;
            play_key(k, oc, pa, ea);
            over = (oc >= 2);
        end
        check("death_reached", oc, 3);
        check("death_php", bus.php, 100);
        check("death_wins", bus.wins, 0);
        check("death_game_won_kept", bus.game_won, 1);

        // clear_game from IDLE drops game_won
        @(negedge clk); bus.clear_game = 1'b1;
        m_clear(1'b0);
        @(negedge clk); bus.clear_game = 1'b0;
        check("clear_idle_game_won", bus.game_won, 0);
        check("clear_idle_php", bus.php, 100);

        repeat (2) @(negedge clk);
        check("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
